// File: rtl/axi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// axi_ram_ctrl: AXI4 burst slave in front of a single-port SRAM with 1-cycle read latency.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_ram_ctrl #(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_MEM  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic       GRANT_RD    = 1'b0;
  localparam logic       GRANT_WR    = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_hold_q, rd_hold_d;

  logic oor;
  logic beat_last;

  assign oor       = (addr_q >> (MEM_AW + 2)) != 32'd0;
  assign beat_last = (cnt_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_WR;
      addr_q       <= 32'd0;
      len_q        <= 8'd0;
      cnt_q        <= 8'd0;
      err_q        <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= 32'd0;
      rd_hold_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      rd_hold_q    <= rd_hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    rd_hold_d    = rd_hold_q;
    arready      = 1'b0;
    awready      = 1'b0;
    rvalid       = 1'b0;
    rdata        = 32'd0;
    rresp        = RESP_OKAY;
    rlast        = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    bresp        = RESP_OKAY;
    mem_en       = 1'b0;
    mem_we       = 4'd0;
    mem_addr     = '0;
    mem_wdata    = 32'd0;

    // Outputs must read zero for the whole reset pulse, even with valids high.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (arvalid && (!awvalid || last_grant_q == GRANT_WR)) begin
            arready      = 1'b1;
            addr_d       = araddr & ~32'h3;
            len_d        = arlen;
            cnt_d        = 8'd0;
            last_grant_d = GRANT_RD;
            state_d      = RD_MEM;
          end else if (awvalid) begin
            awready      = 1'b1;
            addr_d       = awaddr & ~32'h3;
            len_d        = awlen;
            cnt_d        = 8'd0;
            err_d        = RESP_OKAY;
            last_grant_d = GRANT_WR;
            state_d      = WR_DATA;
          end
        end

        RD_MEM: begin
          mem_en    = !oor;
          mem_addr  = addr_q[MEM_AW+1:2];
          rresp_d   = oor ? RESP_DECERR : RESP_OKAY;
          rd_hold_d = 1'b0;
          state_d   = RD_DATA;
        end

        RD_DATA: begin
          rvalid = 1'b1;
          rresp  = rresp_q;
          rlast  = beat_last;
          // SRAM data is only valid in the first RD_DATA cycle; capture it for stalls.
          if (rd_hold_q) begin
            rdata = rdata_q;
          end else if (rresp_q == RESP_DECERR) begin
            rdata = 32'd0;
          end else begin
            rdata = mem_rdata;
          end
          rdata_d   = rdata;
          rd_hold_d = 1'b1;
          if (rready) begin
            if (beat_last) begin
              state_d = IDLE;
            end else begin
              cnt_d   = cnt_q + 8'd1;
              addr_d  = addr_q + 32'd4;
              state_d = RD_MEM;
            end
          end
        end

        WR_DATA: begin
          wready   = 1'b1;
          mem_addr = addr_q[MEM_AW+1:2];
          if (wvalid) begin
            mem_en    = (|wstrb) && !oor;
            mem_we    = wstrb;
            mem_wdata = wdata;
            if (oor) begin
              err_d = RESP_DECERR;
            end else if ((wlast != beat_last) && (err_q != RESP_DECERR)) begin
              err_d = RESP_SLVERR;
            end
            if (beat_last) begin
              state_d = WR_RESP;
            end else begin
              cnt_d  = cnt_q + 8'd1;
              addr_d = addr_q + 32'd4;
            end
          end
        end

        WR_RESP: begin
          bvalid = 1'b1;
          bresp  = err_q;
          if (bready) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_ram_ctrl: randomized self-checking bench for axi_ram_ctrl against a word-array model.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_ram_ctrl;

  localparam int          MEM_AW = 14;
  localparam int          DEPTH  = 1 << MEM_AW;
  localparam logic [31:0] LIMIT  = 32'(4) << MEM_AW;

  logic              clk;
  logic              rst;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int          checks   = 0;
  int          failures = 0;
  bit          tgl      = 1'b0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] sram    [DEPTH];

  axi_ram_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: read data valid one cycle after a read enable, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we == 4'd0) mem_rdata <= sram[mem_addr];
    else                          mem_rdata <= $urandom;
    if (mem_en)
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tgl = ~tgl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {52'd0, arready, rlast, rvalid, awready, wready, bvalid,
                        mem_en, rresp, bresp, mem_we}, 64'd0);
    chk({tag, "_data"}, {rdata, mem_wdata}, 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       rand_addr = 32'hFF00 + 32'($urandom_range(0, 63) * 4);
      1:       rand_addr = $urandom_range(32'h10000, 32'h7FFF_FFFF);
      default: rand_addr = $urandom_range(0, 32'hFFFF);
    endcase
  endfunction

  task automatic start_read(input logic [31:0] a, input int len);
    arvalid = 1'b1; araddr = a; arlen = 8'(len);
    #3;
    chk("ar_grant", {arready, awready}, 2'b10);
    tick();
    arvalid = 1'b0; araddr = $urandom; arlen = 8'($urandom);
  endtask

  task automatic start_write(input logic [31:0] a, input int len);
    awvalid = 1'b1; awaddr = a; awlen = 8'(len);
    #3;
    chk("aw_grant", {arready, awready}, 2'b01);
    tick();
    awvalid = 1'b0; awaddr = $urandom; awlen = 8'($urandom);
  endtask

  // mode: 0 = rready always high, 1 = rready toggles every cycle, 2 = random stalls
  task automatic read_beats(input logic [31:0] addr, input int len, input int mode);
    logic [31:0] a;
    logic [31:0] exp_d;
    bit          ok;
    int          s;
    for (int i = 0; i <= len; i++) begin
      a  = (addr & ~32'h3) + 32'(4 * i);
      ok = a < LIMIT;
      exp_d = ok ? ref_mem[a[MEM_AW+1:2]] : 32'h0;
      #3;
      chk("rd_mem_rvalid", rvalid, 0);
      chk("rd_mem_en", mem_en, ok);
      chk("rd_mem_we", mem_we, 0);
      if (ok) chk("rd_mem_addr", mem_addr, a[MEM_AW+1:2]);
      chk("rd_busy_ready", {arready, awready}, 0);
      tick();
      s = 0;
      while (1) begin
        case (mode)
          0:       rready = 1'b1;
          1:       rready = tgl;
          default: rready = ($urandom_range(0, 2) != 0) || (s > 6);
        endcase
        #3;
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, exp_d);
        chk("rresp", rresp, ok ? 2'b00 : 2'b11);
        chk("rlast", rlast, i == len);
        if (rready) begin
          tick();
          break;
        end
        tick();
        s++;
      end
      rready = 1'b0;
    end
  endtask

  // Stops after 'stop' data beats (no response phase) when stop <= len.
  task automatic write_beats(input logic [31:0] addr, input int len, input int bad,
                             input int stop, input bit fixed,
                             input logic [31:0] d0, input logic [3:0] s0);
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [1:0]  exp_b;
    bit          ok, dec, slv;
    int          dly;
    dec = 1'b0;
    slv = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == stop) begin
        wvalid = 1'b0;
        return;
      end
      a  = (addr & ~32'h3) + 32'(4 * i);
      ok = a < LIMIT;
      while ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        #3;
        chk("wr_stall_en", mem_en, 0);
        chk("wr_stall_wready", wready, 1);
        tick();
      end
      wd = (fixed && i == 0) ? d0 : $urandom;
      ws = (fixed && i == 0) ? s0 : 4'($urandom);
      wvalid = 1'b1; wdata = wd; wstrb = ws;
      wlast  = (i == len) ^ (i == bad);
      #3;
      chk("wr_wready", wready, 1);
      chk("wr_mem_en", mem_en, ok && (ws != 4'd0));
      chk("wr_mem_we", mem_we, ws);
      if (ok) chk("wr_mem_addr", mem_addr, a[MEM_AW+1:2]);
      chk("wr_mem_wdata", mem_wdata, wd);
      if (!ok) dec = 1'b1;
      if (wlast != (i == len)) slv = 1'b1;
      if (ok)
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[a[MEM_AW+1:2]][8*b +: 8] = wd[8*b +: 8];
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    exp_b  = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    dly    = $urandom_range(0, 3);
    for (int d = 0; d < dly; d++) begin
      bready = 1'b0;
      #3;
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, exp_b);
      chk("b_wready", wready, 0);
      tick();
    end
    bready = 1'b1;
    #3;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, exp_b);
    tick();
    bready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          len, bad;

    rst = 1'b1;
    araddr = 32'h200; arlen = 8'd0; arvalid = 1'b1;
    awaddr = 32'h300; awlen = 8'd1; awvalid = 1'b1;
    rready = 1'b0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = $urandom;
      sram[i]    = ref_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Both requests pending from reset: read first, then write, then read again.
    #3;
    chk("arb_first", {arready, awready}, 2'b10);
    tick();
    read_beats(32'h200, 0, 0);
    #3;
    chk("arb_second", {arready, awready}, 2'b01);
    tick();
    write_beats(32'h300, 1, -1, 99, 1'b0, 32'h0, 4'h0);
    #3;
    chk("arb_third", {arready, awready}, 2'b10);
    tick();
    arvalid = 1'b0;
    awvalid = 1'b0;
    read_beats(32'h200, 0, 2);

    // A valid withdrawn before any clock edge starts nothing.
    arvalid = 1'b1; araddr = 32'h0; arlen = 8'd0;
    #3;
    arvalid = 1'b0;
    tick();
    #3;
    chk("withdrawn_ar", {mem_en, rvalid, wready}, 3'b000);
    tick();

    start_write(32'h10, 0);
    write_beats(32'h10, 0, -1, 99, 1'b1, 32'hDEADBEEF, 4'hF);
    start_read(32'h10, 0);
    read_beats(32'h10, 0, 0);

    start_read(32'hFFF8, 3);
    read_beats(32'hFFF8, 3, 2);

    start_write(32'h400, 3);
    write_beats(32'h400, 3, 1, 99, 1'b0, 32'h0, 4'h0);
    start_read(32'h400, 3);
    read_beats(32'h400, 3, 0);

    start_read(32'h100, 255);
    read_beats(32'h100, 255, 1);

    for (int t = 0; t < 40; t++) begin
      a   = rand_addr() | 32'($urandom_range(0, 3));
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        start_read(a, len);
        read_beats(a, len, $urandom_range(0, 2));
      end else begin
        bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
        start_write(a, len);
        write_beats(a, len, bad, 999, 1'b0, 32'h0, 4'h0);
      end
    end

    // Reset in the middle of a write burst, with a beat on the bus.
    start_write(32'h500, 3);
    write_beats(32'h500, 3, -1, 2, 1'b0, 32'h0, 4'h0);
    wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wlast = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_in_burst");
    tick();
    rst    = 1'b0;
    wvalid = 1'b0;
    bready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk("no_bvalid_after_rst", {bvalid, wready}, 2'b00);
      tick();
    end
    bready = 1'b0;
    start_read(32'h500, 3);
    read_beats(32'h500, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
